// File: rtl/div_err_stats.sv
// div_err_stats: windowed accuracy statistics for the compensated divider.
// Accumulates |acc-app|, mismatch count and worst error word over
// 2^WIN_LOG2 accepted samples, then offers the result as a held report.
`timescale 1ns/1ps

module div_err_stats #(
  parameter int WIN_LOG2 = 7,
  parameter int QW       = 8,
  parameter int EW       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [QW-1:0]          app,
  input  logic [QW-1:0]          acc,
  input  logic [EW-1:0]          err,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [QW+WIN_LOG2-1:0] sum_diff,
  output logic [QW-1:0]          mean_diff,
  output logic [QW-1:0]          max_diff,
  output logic [WIN_LOG2:0]      mism_cnt,
  output logic [EW-1:0]          max_err
);

  typedef enum logic {ACCUM, REPORT} state_t;

  state_t                 state_q, state_d;
  logic [WIN_LOG2-1:0]    cnt_q, cnt_d;
  logic [QW+WIN_LOG2-1:0] sum_q, sum_d;
  logic [QW-1:0]          maxd_q, maxd_d;
  logic [WIN_LOG2:0]      mism_q, mism_d;
  logic [EW-1:0]          maxe_q, maxe_d;

  logic                   accept;
  logic                   last;
  logic                   rpt_done;
  logic [QW:0]            pos_wide;
  logic [QW:0]            neg_wide;
  logic [QW-1:0]          diff;

  // Handshake qualifiers; in ACCUM in_ready is high outside reset.
  assign accept   = in_valid & (state_q == ACCUM);
  assign last     = accept & (cnt_q == {WIN_LOG2{1'b1}});
  assign rpt_done = (state_q == REPORT) & rpt_ready;

  // Absolute difference: both subtraction directions, pick the non-negative one.
  assign pos_wide = {1'b0, acc} - {1'b0, app};
  assign neg_wide = {1'b0, app} - {1'b0, acc};
  assign diff     = pos_wide[QW] ? neg_wide[QW-1:0] : pos_wide[QW-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Next-state: clr wins, the final accept enters REPORT, a handshake leaves it.
  always_comb begin
    state_d = state_q;
    if (clr)           state_d = ACCUM;
    else if (last)     state_d = REPORT;
    else if (rpt_done) state_d = ACCUM;
  end

  // FSM outputs; in_ready is forced low while reset is held.
  always_comb begin
    in_ready  = (state_q == ACCUM) & ~rst;
    rpt_valid = (state_q == REPORT);
  end

  // Accumulator update; clearing on clr or on the report handshake.
  always_comb begin
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    maxd_d = maxd_q;
    mism_d = mism_q;
    maxe_d = maxe_q;
    if (clr || rpt_done) begin
      cnt_d  = '0;
      sum_d  = '0;
      maxd_d = '0;
      mism_d = '0;
      maxe_d = '0;
    end else if (accept) begin
      cnt_d  = cnt_q + WIN_LOG2'(1);
      sum_d  = sum_q + {{WIN_LOG2{1'b0}}, diff};
      maxd_d = (diff > maxd_q) ? diff : maxd_q;
      mism_d = mism_q + {{WIN_LOG2{1'b0}}, (acc != app)};
      maxe_d = (err > maxe_q) ? err : maxe_q;
    end
  end

  // Statistics and sample counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sum_q  <= '0;
      maxd_q <= '0;
      mism_q <= '0;
      maxe_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      maxd_q <= maxd_d;
      mism_q <= mism_d;
      maxe_q <= maxe_d;
    end
  end

  assign sum_diff  = sum_q;
  assign mean_diff = sum_q[QW+WIN_LOG2-1:WIN_LOG2];
  assign max_diff  = maxd_q;
  assign mism_cnt  = mism_q;
  assign max_err   = maxe_q;

endmodule

// File: tb/tb_div_err_stats.sv
// tb_div_err_stats: randomized bench for div_err_stats with a queue-based
// reference model. A small-window instance (WIN_LOG2=2) covers control
// behaviour; a default-window instance (WIN_LOG2=7) covers the sum boundary.
`timescale 1ns/1ps

module tb_div_err_stats;

  localparam int QW  = 8;
  localparam int EW  = 16;
  localparam int WL  = 2;
  localparam int BWL = 7;
  localparam int SW  = QW + WL;
  localparam int MW  = WL + 1;
  localparam int BSW = QW + BWL;
  localparam int BMW = BWL + 1;
  localparam int RW  = SW + QW + QW + MW + EW;
  localparam int BRW = BSW + QW + QW + BMW + EW;

  logic clk = 1'b0;
  logic rst;

  logic          clr, in_valid, in_ready, rpt_valid, rpt_ready;
  logic [QW-1:0] app, acc, mean_diff, max_diff;
  logic [EW-1:0] err, max_err;
  logic [SW-1:0] sum_diff;
  logic [MW-1:0] mism_cnt;
  logic [RW-1:0] obs;

  logic           b_clr, b_in_valid, b_in_ready, b_rpt_valid, b_rpt_ready;
  logic [QW-1:0]  b_app, b_acc, b_mean_diff, b_max_diff;
  logic [EW-1:0]  b_err, b_max_err;
  logic [BSW-1:0] b_sum_diff;
  logic [BMW-1:0] b_mism_cnt;
  logic [BRW-1:0] b_obs;

  int total = 0;
  int bad   = 0;

  int s_acc[$], s_app[$], s_err[$];
  int b_acc_q[$], b_app_q[$], b_err_q[$];

  typedef struct {
    int sum;
    int mean;
    int maxd;
    int mism;
    int maxe;
  } stats_t;

  always #5 clk = ~clk;

  div_err_stats #(.WIN_LOG2(WL), .QW(QW), .EW(EW)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .app(app), .acc(acc), .err(err), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .sum_diff(sum_diff), .mean_diff(mean_diff), .max_diff(max_diff),
    .mism_cnt(mism_cnt), .max_err(max_err)
  );

  div_err_stats #(.WIN_LOG2(BWL), .QW(QW), .EW(EW)) u_big (
    .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .app(b_app), .acc(b_acc), .err(b_err), .rpt_valid(b_rpt_valid), .rpt_ready(b_rpt_ready),
    .sum_diff(b_sum_diff), .mean_diff(b_mean_diff), .max_diff(b_max_diff),
    .mism_cnt(b_mism_cnt), .max_err(b_max_err)
  );

  assign obs   = {sum_diff, mean_diff, max_diff, mism_cnt, max_err};
  assign b_obs = {b_sum_diff, b_mean_diff, b_max_diff, b_mism_cnt, b_max_err};

  // Reference: statistics straight from the list of accepted samples.
  function automatic stats_t model(input int a[$], input int p[$], input int e[$], input int wl);
    stats_t r;
    r = '{default: 0};
    foreach (a[i]) begin
      int d;
      d = (a[i] > p[i]) ? a[i] - p[i] : p[i] - a[i];
      r.sum += d;
      if (d > r.maxd) r.maxd = d;
      if (a[i] != p[i]) r.mism++;
      if (e[i] > r.maxe) r.maxe = e[i];
    end
    r.mean = r.sum >> wl;
    return r;
  endfunction

  function automatic logic [RW-1:0] pack_s(input stats_t r);
    return {SW'(r.sum), QW'(r.mean), QW'(r.maxd), MW'(r.mism), EW'(r.maxe)};
  endfunction

  function automatic logic [BRW-1:0] pack_b(input stats_t r);
    return {BSW'(r.sum), QW'(r.mean), QW'(r.maxd), BMW'(r.mism), EW'(r.maxe)};
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample to the small instance and wait (bounded) for acceptance.
  task automatic send(input int a, input int p, input int e);
    int n;
    n = 0;
    acc = QW'(a); app = QW'(p); err = EW'(e); in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("[TB] FAIL send_timeout in_ready=%b required=1", in_ready);
    end else begin
      step();
      s_acc.push_back(a); s_app.push_back(p); s_err.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  // Same as send, for the large-window instance.
  task automatic b_send(input int a, input int p, input int e);
    int n;
    n = 0;
    b_acc = QW'(a); b_app = QW'(p); b_err = EW'(e); b_in_valid = 1'b1;
    while (!b_in_ready && n < 50) begin
      step();
      n++;
    end
    total++;
    if (!b_in_ready) begin
      bad++;
      $display("[TB] FAIL b_send_timeout in_ready=%b required=1", b_in_ready);
    end else begin
      step();
      b_acc_q.push_back(a); b_app_q.push_back(p); b_err_q.push_back(e);
    end
    b_in_valid = 1'b0;
  endtask

  task automatic clear_model();
    s_acc.delete(); s_app.delete(); s_err.delete();
  endtask

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b0 || rpt_valid !== 1'b0 || obs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_hold ready=%b valid=%b stats=%h required 0/0/0", in_ready, rpt_valid, obs);
    end
    rst = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1 || rpt_valid !== 1'b0 || obs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_release ready=%b valid=%b stats=%h required 1/0/0", in_ready, rpt_valid, obs);
    end
    send(10, 8, 0);
    total++;
    if (obs !== pack_s(model(s_acc, s_app, s_err, WL))) begin
      bad++;
      $display("[TB] FAIL reset_live got=%h required=%h", obs, pack_s(model(s_acc, s_app, s_err, WL)));
    end
    acc = 8'd9; app = 8'd1; err = 16'd3; in_valid = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || rpt_valid !== 1'b0 || obs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_async ready=%b valid=%b stats=%h required 0/0/0", in_ready, rpt_valid, obs);
    end
    step();
    #3;
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1 || obs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_restart ready=%b stats=%h required 1/0", in_ready, obs);
    end
    clear_model();
  endtask

  task automatic test_basic();
    int ta[4] = '{10, 5, 3, 200};
    int tp[4] = '{8, 5, 7, 199};
    int te[4] = '{0, 3, 100, 65535};
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tp[i], te[i]);
      if (i < 3) begin
        total++;
        if (rpt_valid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL basic_early_valid sample=%0d valid=%b required=0", i, rpt_valid);
        end
      end
    end
    total++;
    if (rpt_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_valid valid=%b ready=%b required 1/0", rpt_valid, in_ready);
    end
    total++;
    if (obs !== {SW'(7), QW'(1), QW'(4), MW'(3), EW'(65535)}) begin
      bad++;
      $display("[TB] FAIL basic_report got=%h required=%h", obs, {SW'(7), QW'(1), QW'(4), MW'(3), EW'(65535)});
    end
  endtask

  task automatic test_backpressure();
    rpt_ready = 1'b0;
    acc = 8'd9; app = 8'd1; err = 16'd5; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (in_ready !== 1'b0 || rpt_valid !== 1'b1 ||
          obs !== {SW'(7), QW'(1), QW'(4), MW'(3), EW'(65535)}) begin
        bad++;
        $display("[TB] FAIL bp_hold cycle=%0d ready=%b valid=%b stats=%h", i, in_ready, rpt_valid, obs);
      end
    end
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    in_valid = 1'b0;
    total++;
    if (rpt_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      bad++;
      $display("[TB] FAIL bp_release valid=%b ready=%b stats=%h required 0/1/0", rpt_valid, in_ready, obs);
    end
    clear_model();
  endtask

  task automatic test_clr_collision();
    send(3, 1, 4);
    send(1, 6, 2);
    clr = 1'b1; acc = 8'd9; app = 8'd1; err = 16'd9; in_valid = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0;
    clear_model();
    total++;
    if (obs !== '0 || rpt_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clr_drop stats=%h valid=%b ready=%b required 0/0/1", obs, rpt_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) send(50, 50, 7);
    total++;
    if (rpt_valid !== 1'b1 || obs !== {SW'(0), QW'(0), QW'(0), MW'(0), EW'(7)}) begin
      bad++;
      $display("[TB] FAIL clr_window valid=%b got=%h required=%h", rpt_valid, obs,
               {SW'(0), QW'(0), QW'(0), MW'(0), EW'(7)});
    end
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    clear_model();
  endtask

  task automatic test_clr_report();
    for (int i = 0; i < 4; i++)
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
    total++;
    if (rpt_valid !== 1'b1 || obs !== pack_s(model(s_acc, s_app, s_err, WL))) begin
      bad++;
      $display("[TB] FAIL clrrpt_report valid=%b got=%h required=%h", rpt_valid, obs,
               pack_s(model(s_acc, s_app, s_err, WL)));
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    clear_model();
    total++;
    if (rpt_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      bad++;
      $display("[TB] FAIL clrrpt_discard valid=%b ready=%b stats=%h required 0/1/0", rpt_valid, in_ready, obs);
    end
    for (int i = 0; i < 4; i++)
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
    total++;
    if (rpt_valid !== 1'b1 || obs !== pack_s(model(s_acc, s_app, s_err, WL))) begin
      bad++;
      $display("[TB] FAIL clrrpt_restart valid=%b got=%h required=%h", rpt_valid, obs,
               pack_s(model(s_acc, s_app, s_err, WL)));
    end
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    clear_model();
  endtask

  task automatic test_random();
    for (int w = 0; w < 8; w++) begin
      for (int s = 0; s < 4; s++) begin
        int gap, a, p;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          rpt_ready = 1'($urandom_range(0, 1));
          step();
        end
        a = $urandom_range(0, 255);
        p = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 255);
        send(a, p, $urandom_range(0, 65535));
        rpt_ready = 1'b0;
        total++;
        if (rpt_valid !== (s == 3) || obs !== pack_s(model(s_acc, s_app, s_err, WL))) begin
          bad++;
          $display("[TB] FAIL random_stats win=%0d smp=%0d valid=%b got=%h required=%h", w, s,
                   rpt_valid, obs, pack_s(model(s_acc, s_app, s_err, WL)));
        end
      end
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        step();
        total++;
        if (rpt_valid !== 1'b1 || obs !== pack_s(model(s_acc, s_app, s_err, WL))) begin
          bad++;
          $display("[TB] FAIL random_hold win=%0d valid=%b got=%h", w, rpt_valid, obs);
        end
      end
      rpt_ready = 1'b1;
      step();
      rpt_ready = 1'b0;
      clear_model();
      total++;
      if (rpt_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
        bad++;
        $display("[TB] FAIL random_clear win=%0d valid=%b ready=%b stats=%h", w, rpt_valid, in_ready, obs);
      end
    end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 128; i++) begin
      b_send(255, 0, 0);
      if (i == 126) begin
        total++;
        if (b_rpt_valid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL bound_early_valid valid=%b required=0", b_rpt_valid);
        end
      end
    end
    total++;
    if (b_rpt_valid !== 1'b1 || b_obs !== {BSW'(32640), QW'(255), QW'(255), BMW'(128), EW'(0)}) begin
      bad++;
      $display("[TB] FAIL bound_report valid=%b got=%h required=%h", b_rpt_valid, b_obs,
               {BSW'(32640), QW'(255), QW'(255), BMW'(128), EW'(0)});
    end
    b_rpt_ready = 1'b1;
    step();
    b_rpt_ready = 1'b0;
    b_acc_q.delete(); b_app_q.delete(); b_err_q.delete();
    for (int i = 0; i < 128; i++)
      b_send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
    total++;
    if (b_rpt_valid !== 1'b1 || b_obs !== pack_b(model(b_acc_q, b_app_q, b_err_q, BWL))) begin
      bad++;
      $display("[TB] FAIL bound_random valid=%b got=%h required=%h", b_rpt_valid, b_obs,
               pack_b(model(b_acc_q, b_app_q, b_err_q, BWL)));
    end
    b_rpt_ready = 1'b1;
    step();
    b_rpt_ready = 1'b0;
    total++;
    if (b_rpt_valid !== 1'b0 || b_in_ready !== 1'b1 || b_obs !== '0) begin
      bad++;
      $display("[TB] FAIL bound_clear valid=%b ready=%b stats=%h", b_rpt_valid, b_in_ready, b_obs);
    end
  endtask

  // Bound the whole run in case the design stops making progress.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    rst = 1'b1;
    clr = 1'b0; in_valid = 1'b0; rpt_ready = 1'b0; app = '0; acc = '0; err = '0;
    b_clr = 1'b0; b_in_valid = 1'b0; b_rpt_ready = 1'b0; b_app = '0; b_acc = '0; b_err = '0;
    step();
    step();
    test_reset();
    test_basic();
    test_backpressure();
    test_clr_collision();
    test_clr_report();
    test_random();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
